ddr_port_arbiter: RTL and testbench

//   Shares the single 256-bit line port of the DDR control block between two requesters
//   (port 0: I-cache refill, port 1: D-cache refill/writeback).
//   - Round-robin arbitration between the two ports.
//   - Latches the granted request and holds it stable on the controller port until the

---
 rtl/ddr_port_arbiter_if.sv | 30 +++
 rtl/ddr_port_arbiter.sv | 121 ++++++++++++
 tb/tb_ddr_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_port_arbiter_if.sv
// Bundles the requester-side and controller-side signals of the DDR line port arbiter.
// req_valid/req_ready: a port holds req_valid with stable write/addr/wdata until a one-cycle req_ready accepts it.
interface ddr_port_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256
);
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic                ram_en;
  logic                ram_write;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   data_to_ram;
  logic                ram_rdy;
  logic [DATA_W-1:0]   data_from_ram;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ram_rdy, data_from_ram,
    output req_ready, resp_valid, resp_rdata, ram_en, ram_write, ram_addr, data_to_ram
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ram_rdy, data_from_ram,
    input  req_ready, resp_valid, resp_rdata, ram_en, ram_write, ram_addr, data_to_ram
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing the DDR controller line port between the I-cache (port 0)
// and D-cache (port 1) miss handlers; holds the granted op stable until completion.
module ddr_port_arbiter #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 256,
  parameter int ACCEPT_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  ddr_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  localparam int CNT_W = $clog2(ACCEPT_WAIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_WAIT - 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                ptr;
  logic                owner;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                grant;
  logic                take;
  logic                capture;
  logic                en_raw;
  logic [1:0]          ready_raw;
  logic [1:0]          resp_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        owner     <= grant;
        ptr       <= ~grant;
        lat_write <= grant ? bus.req_write[1] : bus.req_write[0];
        lat_addr  <= grant ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        lat_wdata <= grant ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      end
      if (capture) begin
        rdata_q <= bus.data_from_ram;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    grant     = ptr;
    take      = 1'b0;
    capture   = 1'b0;
    en_raw    = 1'b0;
    ready_raw = 2'b00;
    resp_raw  = 2'b00;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          grant     = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
          take      = 1'b1;
          ready_raw = grant ? 2'b10 : 2'b01;
          cnt_n     = '0;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        en_raw = 1'b1;
        // A controller that stays ready this long has silently absorbed a repeated op.
        if (!bus.ram_rdy) begin
          cnt_n   = '0;
          state_n = BUSY;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          capture = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BUSY: begin
        en_raw = 1'b1;
        if (bus.ram_rdy) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        en_raw   = 1'b1;
        resp_raw = owner ? 2'b10 : 2'b01;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs stay quiet while reset is held so nothing is accepted or reported.
  assign bus.req_ready   = reset ? 2'b00 : ready_raw;
  assign bus.resp_valid  = reset ? 2'b00 : resp_raw;
  assign bus.ram_en      = en_raw & ~reset;
  assign bus.ram_write   = lat_write;
  assign bus.ram_addr    = lat_addr;
  assign bus.data_to_ram = lat_wdata;
  assign bus.resp_rdata  = rdata_q;
  assign busy            = (state != IDLE) & ~reset;
  assign dbg_state       = state;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: directed vector table, hand sequences for
// long/abandoned ops, and a randomized run against a transaction-level reference model.
module tb_ddr_port_arbiter;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 256;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [1:0] dbg_state;

  ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCEPT_WAIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic        rdy;
    logic [1:0]  e_rr;
    logic [1:0]  e_rsp;
    logic        e_en;
    logic        e_wr;
    logic        e_busy;
    logic [29:0] e_addr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] l;
    for (int i = 0; i < DATA_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic add(input logic rst, input logic [1:0] rv, input logic rdy,
                     input logic [1:0] e_rr, input logic [1:0] e_rsp,
                     input logic e_en, input logic e_wr, input logic e_busy,
                     input logic [29:0] e_addr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rdy = rdy; v.e_rr = e_rr; v.e_rsp = e_rsp;
    v.e_en = e_en; v.e_wr = e_wr; v.e_busy = e_busy; v.e_addr = e_addr;
    vt.push_back(v);
  endtask

  task automatic set_port(input int p, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    bus.req_write[p] = wr;
    if (p == 0) begin
      bus.req_addr[ADDR_W-1:0]  = a;
      bus.req_wdata[DATA_W-1:0] = d;
    end else begin
      bus.req_addr[2*ADDR_W-1:ADDR_W]  = a;
      bus.req_wdata[2*DATA_W-1:DATA_W] = d;
    end
  endtask

  // reference model state: transaction level
  int                m_phase;    // 0 idle, 1 op outstanding at controller, 2 completion cycle
  logic              m_next;
  logic              m_owner;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  bit                rdy_hist[$];
  logic [1:0]        got_rdy;

  task automatic model_reset();
    m_phase = 0; m_next = 1'b0; m_owner = 1'b0; m_write = 1'b0;
    m_addr = '0; m_wdata = '0; rdy_hist.delete(); got_rdy = 2'b00; exp_q.delete();
  endtask

  task automatic rand_cycle(input bit allow_new);
    logic [1:0] e_rr, e_rsp;
    logic       e_en;
    logic       g;
    int         k, n;
    bit         done;
    for (int p = 0; p < 2; p++) begin
      if (bus.req_valid[p] && got_rdy[p]) begin
        bus.req_valid[p] = 1'b0;
        set_port(p, $urandom_range(0, 1), ADDR_W'($urandom), rand_line());
      end else if (bus.req_valid[p] && $urandom_range(0, 15) == 0) begin
        bus.req_valid[p] = 1'b0;
      end else if (!bus.req_valid[p] && allow_new && $urandom_range(0, 2) == 0) begin
        bus.req_valid[p] = 1'b1;
        set_port(p, $urandom_range(0, 1), ADDR_W'($urandom), rand_line());
      end
    end
    bus.ram_rdy       = ($urandom_range(0, 3) != 0) || !allow_new;
    bus.data_from_ram = rand_line();
    #1;
    e_rr = 2'b00; e_rsp = 2'b00; e_en = 1'b0; g = 1'b0;
    if (m_phase == 0 && bus.req_valid != 2'b00) begin
      g    = (bus.req_valid == 2'b11) ? m_next : bus.req_valid[1];
      e_rr = g ? 2'b10 : 2'b01;
    end
    if (m_phase != 0) e_en = 1'b1;
    if (m_phase == 2) e_rsp = m_owner ? 2'b10 : 2'b01;
    chk("rnd_req_ready", bus.req_ready, e_rr);
    chk("rnd_resp_valid", bus.resp_valid, e_rsp);
    chk("rnd_ram_en", bus.ram_en, e_en);
    chk("rnd_busy", busy, m_phase != 0);
    chk("rnd_ram_write", bus.ram_write, m_write);
    chk("rnd_ram_addr", bus.ram_addr, m_addr);
    chk("rnd_data_to_ram", bus.data_to_ram, m_wdata);
    if (bus.resp_valid != 2'b00 && !m_write) begin
      if (exp_q.size() == 0) chk("rnd_unexpected_read_resp", 1, 0);
      else chk("rnd_resp_rdata", bus.resp_rdata, exp_q.pop_front());
    end
    got_rdy = bus.req_ready;
    case (m_phase)
      0: if (bus.req_valid != 2'b00) begin
        m_owner = g;
        m_next  = ~g;
        m_write = bus.req_write[g];
        m_addr  = g ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        m_wdata = g ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
        rdy_hist.delete();
        m_phase = 1;
      end
      1: begin
        // Satisfied by four straight ready cycles, or by ready returning after it dropped.
        rdy_hist.push_back(bus.ram_rdy);
        n = rdy_hist.size();
        k = -1;
        for (int i = n - 1; i >= 0; i--) if (!rdy_hist[i]) k = i;
        if (k < 0) done = (n >= 4);
        else done = (k < 4) && rdy_hist[n-1] && (n - 1 > k);
        if (done) begin
          m_phase = 2;
          if (!m_write) exp_q.push_back(bus.data_from_ram);
        end
      end
      default: m_phase = 0;
    endcase
    tick();
  endtask

  initial begin
    logic [DATA_W-1:0] line_a, line_b, wline;
    reset = 1'b1;
    bus.req_valid = 2'b00; bus.req_write = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ram_rdy = 1'b1; bus.data_from_ram = '0;
    tick(); tick();

    // directed vector table: arbitration from reset and back-to-back P1 writes
    add(1, 2'b11, 1, 2'b00, 2'b00, 0, 0, 0, 30'h0);
    add(0, 2'b11, 1, 2'b01, 2'b00, 0, 0, 0, 30'h0);
    repeat (4) add(0, 2'b10, 1, 2'b00, 2'b00, 1, 0, 1, 30'h40);
    add(0, 2'b10, 1, 2'b00, 2'b01, 1, 0, 1, 30'h40);
    add(0, 2'b10, 1, 2'b10, 2'b00, 0, 0, 0, 30'h40);
    repeat (4) add(0, 2'b00, 1, 2'b00, 2'b00, 1, 1, 1, 30'h80);
    add(0, 2'b00, 1, 2'b00, 2'b10, 1, 1, 1, 30'h80);
    add(0, 2'b00, 1, 2'b00, 2'b00, 0, 1, 0, 30'h80);
    repeat (2) begin
      add(0, 2'b10, 1, 2'b10, 2'b00, 0, 1, 0, 30'h80);
      repeat (4) add(0, 2'b00, 1, 2'b00, 2'b00, 1, 1, 1, 30'h80);
      add(0, 2'b00, 1, 2'b00, 2'b10, 1, 1, 1, 30'h80);
    end
    add(0, 2'b00, 1, 2'b00, 2'b00, 0, 1, 0, 30'h80);

    set_port(0, 1'b0, 30'h40, '0);
    set_port(1, 1'b1, 30'h80, '0);
    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; bus.req_valid = vt[i].rv; bus.ram_rdy = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_req_ready", i), bus.req_ready, vt[i].e_rr);
      chk($sformatf("vec%0d_resp_valid", i), bus.resp_valid, vt[i].e_rsp);
      chk($sformatf("vec%0d_ram_en", i), bus.ram_en, vt[i].e_en);
      chk($sformatf("vec%0d_ram_write", i), bus.ram_write, vt[i].e_wr);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vt[i].e_addr);
      tick();
    end

    // port 0 read that stalls in BUSY for 20 cycles; requester moves its address afterwards
    line_a = rand_line();
    set_port(0, 1'b0, 30'h100, '0);
    bus.req_valid = 2'b01; bus.ram_rdy = 1'b1;
    #1; chk("t1_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    set_port(0, 1'b1, 30'h3ff, rand_line());
    for (int i = 0; i < 3; i++) begin
      bus.ram_rdy = (i < 2);
      #1; chk("t1_issue_en", bus.ram_en, 1); chk("t1_issue_addr", bus.ram_addr, 30'h100);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      bus.ram_rdy = 1'b0;
      #1; chk("t1_busy_en", bus.ram_en, 1); chk("t1_busy_resp", bus.resp_valid, 0);
      chk("t1_busy_addr", bus.ram_addr, 30'h100); chk("t1_busy_write", bus.ram_write, 0);
      tick();
    end
    bus.ram_rdy = 1'b1; bus.data_from_ram = line_a;
    #1; chk("t1_pre_done_resp", bus.resp_valid, 0);
    tick();
    bus.data_from_ram = ~line_a;
    #1; chk("t1_done_resp", bus.resp_valid, 2'b01); chk("t1_done_rdata", bus.resp_rdata, line_a);
    chk("t1_done_en", bus.ram_en, 1);
    tick();
    #1; chk("t1_idle_resp", bus.resp_valid, 0); chk("t1_idle_busy", busy, 0);
    chk("t1_idle_en", bus.ram_en, 0); chk("t1_rdata_held", bus.resp_rdata, line_a);

    // reset abandons an op stuck in BUSY
    set_port(0, 1'b0, 30'h55, '0);
    bus.req_valid = 2'b01;
    #1; chk("t5_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00; bus.ram_rdy = 1'b0;
    tick(); tick();
    reset = 1'b1; bus.ram_rdy = 1'b1;
    tick();
    reset = 1'b0;
    #1; chk("t5_en_after_reset", bus.ram_en, 0); chk("t5_busy_after_reset", busy, 0);
    chk("t5_resp_after_reset", bus.resp_valid, 0);
    tick();
    #1; chk("t5_resp_later", bus.resp_valid, 0);

    // both valid after reset: port 0 first, port 1 waits through DONE; fields held stable
    wline = rand_line();
    set_port(0, 1'b1, 30'h77, wline);
    set_port(1, 1'b0, 30'h99, '0);
    bus.req_valid = 2'b11;
    #1; chk("t6_grant_p0", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b10;
    set_port(0, 1'b0, 30'h12, rand_line());
    for (int i = 0; i < 4; i++) begin
      #1; chk("t6_addr_stable", bus.ram_addr, 30'h77); chk("t6_write_stable", bus.ram_write, 1);
      chk("t6_wdata_stable", bus.data_to_ram, wline); chk("t6_p1_waits", bus.req_ready, 0);
      tick();
    end
    #1; chk("t6_done_resp", bus.resp_valid, 2'b01); chk("t6_done_addr", bus.ram_addr, 30'h77);
    chk("t6_done_wdata", bus.data_to_ram, wline); chk("t6_done_no_grant", bus.req_ready, 0);
    tick();
    #1; chk("t6_grant_p1", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    line_b = rand_line();
    for (int i = 0; i < 4; i++) begin
      bus.data_from_ram = (i == 3) ? line_b : rand_line();
      #1; chk("t6_p1_addr", bus.ram_addr, 30'h99); chk("t6_p1_write", bus.ram_write, 0);
      tick();
    end
    bus.data_from_ram = rand_line();
    #1; chk("t6_p1_resp", bus.resp_valid, 2'b10); chk("t6_p1_rdata", bus.resp_rdata, line_b);
    tick();

    // randomized traffic against the reference model
    reset = 1'b1; bus.req_valid = 2'b00;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 800; i++) rand_cycle(1'b1);
    for (int i = 0; i < 16; i++) rand_cycle(1'b0);
    chk("rnd_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
